// File: rtl/regfile_param.sv
// regfile_param: multi-ported register file with an issue scoreboard.
// It has two combinational read ports and one synchronous write port.
// Register 0 is hardwired to zero. Write-to-read forwarding is optional.
// Each register has one busy bit that tracks a write still in flight.
module regfile_param #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       regWr,
    input  logic [$clog2(DEPTH)-1:0]   rW,
    input  logic [WIDTH-1:0]           busW,
    input  logic [$clog2(DEPTH)-1:0]   rS1,
    input  logic [$clog2(DEPTH)-1:0]   rS2,
    output logic [WIDTH-1:0]           busA,
    output logic [WIDTH-1:0]           busB,
    input  logic                       setBusy,
    input  logic [$clog2(DEPTH)-1:0]   rBusy,
    output logic                       busyA,
    output logic                       busyB,
    output logic                       anyBusy
);

    localparam int AW = $clog2(DEPTH);

    // Bit 0 of the scoreboard can never be set; the register it covers is constant.
    localparam logic [DEPTH-1:0] BUSY_MASK = {{(DEPTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;

    logic             wr_en;
    logic             set_en;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;

    logic             fwd_a;
    logic             fwd_b;
    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;

    // A write to r0 is dropped here, so r0 storage keeps its reset value of zero.
    assign wr_en  = regWr && (rW != '0);
    assign set_en = setBusy && (rBusy != '0);

    // Decode the scoreboard set and clear requests into one-hot vectors.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) begin
            set_vec[rBusy] = 1'b1;
        end
        if (wr_en) begin
            clr_vec[rW] = 1'b1;
        end
    end

    // Register storage. It is cleared asynchronously and written on the rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[rW] <= busW;
        end
    end

    // Scoreboard update. The set term is ORed in after the clear,
    // so a new issue wins over a write that retires on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_vec) | set_vec) & BUSY_MASK;
        end
    end

    // Forwarding detect. wr_en already excludes r0, so r0 is never forwarded.
    always_comb begin
        fwd_a = 1'b0;
        fwd_b = 1'b0;
        if (BYPASS != 0) begin
            fwd_a = wr_en && (rS1 == rW);
            fwd_b = wr_en && (rS2 == rW);
        end
    end

    // Stored-value lookup. r0 is forced to zero explicitly, independent of storage.
    always_comb begin
        stored_a = (rS1 == '0) ? '0 : mem[rS1];
        stored_b = (rS2 == '0) ? '0 : mem[rS2];
    end

    // Read ports. Reset masks everything, including the forwarding path.
    always_comb begin
        busA = '0;
        busB = '0;
        if (!reset) begin
            busA = fwd_a ? busW : stored_a;
            busB = fwd_b ? busW : stored_b;
        end
    end

    // Busy outputs. A forwarded operand is no longer waiting on its producer.
    always_comb begin
        busyA   = 1'b0;
        busyB   = 1'b0;
        anyBusy = 1'b0;
        if (!reset) begin
            busyA   = busy[rS1] && !fwd_a;
            busyB   = busy[rS2] && !fwd_b;
            anyBusy = |busy;
        end
    end

    // AW is derived from DEPTH and kept local so that it cannot be overridden.
    if (AW < 2) begin : g_depth_too_small
        $error("regfile_param: DEPTH must be at least 4");
    end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: scoreboard-driven bench for regfile_param.
// u0 has forwarding enabled and u1 has it disabled; both take the same stimulus.
// u2 is a 16-bit x 8 instance. All three instances share one reset.
module tb_regfile_param;
    localparam int W  = 32;
    localparam int D  = 32;
    localparam int A  = 5;
    localparam int W2 = 16;
    localparam int D2 = 8;
    localparam int A2 = 3;

    logic clk = 1'b0;
    logic reset;

    logic         regWr, setBusy;
    logic [A-1:0] rW, rS1, rS2, rBusy;
    logic [W-1:0] busW;
    logic [W-1:0] busA0, busB0, busA1, busB1;
    logic         busyA0, busyB0, any0, busyA1, busyB1, any1;

    logic          regWr2, setBusy2;
    logic [A2-1:0] rW2, rS12, rS22, rBusy2;
    logic [W2-1:0] busW2, busA2, busB2;
    logic          busyA2, busyB2, any2;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] e;
    logic [W-1:0] ref_mem[D];
    logic [D-1:0] ref_busy;

    always #5 clk = ~clk;

    regfile_param #(.WIDTH(W), .DEPTH(D), .BYPASS(1)) u0 (
        .clk(clk), .reset(reset), .regWr(regWr), .rW(rW), .busW(busW),
        .rS1(rS1), .rS2(rS2), .busA(busA0), .busB(busB0),
        .setBusy(setBusy), .rBusy(rBusy), .busyA(busyA0), .busyB(busyB0), .anyBusy(any0));

    regfile_param #(.WIDTH(W), .DEPTH(D), .BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .regWr(regWr), .rW(rW), .busW(busW),
        .rS1(rS1), .rS2(rS2), .busA(busA1), .busB(busB1),
        .setBusy(setBusy), .rBusy(rBusy), .busyA(busyA1), .busyB(busyB1), .anyBusy(any1));

    regfile_param #(.WIDTH(W2), .DEPTH(D2), .BYPASS(1)) u2 (
        .clk(clk), .reset(reset), .regWr(regWr2), .rW(rW2), .busW(busW2),
        .rS1(rS12), .rS2(rS22), .busA(busA2), .busB(busB2),
        .setBusy(setBusy2), .rBusy(rBusy2), .busyA(busyA2), .busyB(busyB2), .anyBusy(any2));

    task automatic idle();
        regWr = 0; setBusy = 0; rW = '0; rS1 = '0; rS2 = '0; rBusy = '0; busW = '0;
        regWr2 = 0; setBusy2 = 0; rW2 = '0; rS12 = '0; rS22 = '0; rBusy2 = '0; busW2 = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
        ref_busy = '0;
    endtask

    // Advance one cycle: apply the reference model at the rising edge, then return at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            if (regWr && rW != 0) ref_mem[rW] = busW;
            for (int i = 1; i < D; i++) begin
                if (setBusy && rBusy == A'(i)) ref_busy[i] = 1'b1;
                else if (regWr && rW == A'(i)) ref_busy[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] exp_read(input logic [A-1:0] a, input bit byp);
        if (byp && regWr && rW != 0 && a == rW) return busW;
        if (a == 0) return '0;
        return ref_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [A-1:0] a, input bit byp);
        return ref_busy[a] && !(byp && regWr && rW != 0 && a == rW);
    endfunction

    task automatic test_reset();
        reset = 1; regWr = 1; rW = 4; busW = 32'hFFFF_FFFF; rS1 = 4; rS2 = 4; setBusy = 1; rBusy = 4;
        @(posedge clk); @(negedge clk);
        exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busA0 !== e[W-1:0]) begin errors++; $display("FAIL rst_fwd_busA got %h exp %h", busA0, e[W-1:0]); end
        e = exp_q.pop_front(); checks++;
        if (busB0 !== e[W-1:0]) begin errors++; $display("FAIL rst_fwd_busB got %h exp %h", busB0, e[W-1:0]); end
        e = exp_q.pop_front(); checks++;
        if (busyA0 !== e[0]) begin errors++; $display("FAIL rst_busyA got %b exp %b", busyA0, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (any0 !== e[0]) begin errors++; $display("FAIL rst_anyBusy got %b exp %b", any0, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (busA1 !== e[W-1:0]) begin errors++; $display("FAIL rst_u1_busA got %h exp %h", busA1, e[W-1:0]); end
        @(negedge clk);
        idle(); reset = 0; model_clear();
        for (int i = 0; i < D; i++) begin
            rS1 = A'(i); rS2 = A'(D - 1 - i);
            exp_q.push_back(64'd0); exp_q.push_back(64'd0);
            #1;
            e = exp_q.pop_front(); checks++;
            if (busA0 !== e[W-1:0]) begin errors++; $display("FAIL rst_read_busA r%0d got %h exp %h", i, busA0, e[W-1:0]); end
            e = exp_q.pop_front(); checks++;
            if (busB0 !== e[W-1:0]) begin errors++; $display("FAIL rst_read_busB r%0d got %h exp %h", D-1-i, busB0, e[W-1:0]); end
        end
        exp_q.push_back(64'd0);
        e = exp_q.pop_front(); checks++;
        if (any0 !== e[0]) begin errors++; $display("FAIL post_rst_anyBusy got %b exp %b", any0, e[0]); end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        regWr = 1; rW = 5; busW = 32'hDEAD_BEEF;
        tick();
        idle(); rS1 = 5; rS2 = 5;
        exp_q.push_back(64'hDEAD_BEEF); exp_q.push_back(64'hDEAD_BEEF);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busA0 !== e[W-1:0]) begin errors++; $display("FAIL wr_r5_busA got %h exp %h", busA0, e[W-1:0]); end
        e = exp_q.pop_front(); checks++;
        if (busB1 !== e[W-1:0]) begin errors++; $display("FAIL wr_r5_u1_busB got %h exp %h", busB1, e[W-1:0]); end
        regWr = 1; rW = 0; busW = 32'h0000_1234; rS1 = 0; rS2 = 0;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busA0 !== e[W-1:0]) begin errors++; $display("FAIL wr_r0_nofwd_busA got %h exp %h", busA0, e[W-1:0]); end
        e = exp_q.pop_front(); checks++;
        if (busB0 !== e[W-1:0]) begin errors++; $display("FAIL wr_r0_nofwd_busB got %h exp %h", busB0, e[W-1:0]); end
        tick();
        idle(); rS1 = 0;
        exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busA0 !== e[W-1:0]) begin errors++; $display("FAIL wr_r0_read got %h exp %h", busA0, e[W-1:0]); end
        @(negedge clk);
    endtask

    task automatic test_bypass();
        regWr = 1; rW = 7; busW = 32'h1111_1111;
        tick();
        idle(); regWr = 1; rW = 7; busW = 32'hA5A5_A5A5; rS1 = 7; rS2 = 7;
        exp_q.push_back(64'hA5A5_A5A5); exp_q.push_back(64'hA5A5_A5A5);
        exp_q.push_back(64'h1111_1111); exp_q.push_back(64'h1111_1111);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busA0 !== e[W-1:0]) begin errors++; $display("FAIL byp1_busA got %h exp %h", busA0, e[W-1:0]); end
        e = exp_q.pop_front(); checks++;
        if (busB0 !== e[W-1:0]) begin errors++; $display("FAIL byp1_busB got %h exp %h", busB0, e[W-1:0]); end
        e = exp_q.pop_front(); checks++;
        if (busA1 !== e[W-1:0]) begin errors++; $display("FAIL byp0_busA got %h exp %h", busA1, e[W-1:0]); end
        e = exp_q.pop_front(); checks++;
        if (busB1 !== e[W-1:0]) begin errors++; $display("FAIL byp0_busB got %h exp %h", busB1, e[W-1:0]); end
        tick();
        idle(); rS1 = 7;
        exp_q.push_back(64'hA5A5_A5A5);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busA1 !== e[W-1:0]) begin errors++; $display("FAIL byp0_after_busA got %h exp %h", busA1, e[W-1:0]); end
        @(negedge clk);
    endtask

    task automatic test_busy();
        setBusy = 1; rBusy = 9;
        tick();
        idle(); rS1 = 9; rS2 = 9;
        exp_q.push_back(64'd1); exp_q.push_back(64'd1); exp_q.push_back(64'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busyA0 !== e[0]) begin errors++; $display("FAIL busy9_busyA got %b exp %b", busyA0, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (any0 !== e[0]) begin errors++; $display("FAIL busy9_anyBusy got %b exp %b", any0, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (busyB1 !== e[0]) begin errors++; $display("FAIL busy9_u1_busyB got %b exp %b", busyB1, e[0]); end
        regWr = 1; rW = 9; busW = 32'hCAFE_F00D;
        exp_q.push_back(64'd0); exp_q.push_back(64'd1); exp_q.push_back(64'hCAFE_F00D);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busyA0 !== e[0]) begin errors++; $display("FAIL busy9_fwd_busyA got %b exp %b", busyA0, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (busyA1 !== e[0]) begin errors++; $display("FAIL busy9_nofwd_busyA got %b exp %b", busyA1, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (busA0 !== e[W-1:0]) begin errors++; $display("FAIL busy9_fwd_busA got %h exp %h", busA0, e[W-1:0]); end
        tick();
        idle(); rS1 = 9;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busyA0 !== e[0]) begin errors++; $display("FAIL busy9_cleared got %b exp %b", busyA0, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (any0 !== e[0]) begin errors++; $display("FAIL busy9_any_cleared got %b exp %b", any0, e[0]); end
        setBusy = 1; rBusy = 0;
        tick();
        idle(); rS1 = 0;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busyA0 !== e[0]) begin errors++; $display("FAIL busy_r0_busyA got %b exp %b", busyA0, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (any0 !== e[0]) begin errors++; $display("FAIL busy_r0_anyBusy got %b exp %b", any0, e[0]); end
        @(negedge clk);
    endtask

    task automatic test_same_edge();
        setBusy = 1; rBusy = 3; regWr = 1; rW = 3; busW = 32'h3333_3333;
        tick();
        idle(); rS1 = 3;
        exp_q.push_back(64'h3333_3333); exp_q.push_back(64'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busA0 !== e[W-1:0]) begin errors++; $display("FAIL same_edge_data got %h exp %h", busA0, e[W-1:0]); end
        e = exp_q.pop_front(); checks++;
        if (busyA0 !== e[0]) begin errors++; $display("FAIL same_edge_busy got %b exp %b", busyA0, e[0]); end
        @(negedge clk);
    endtask

    task automatic test_small_async_reset();
        regWr2 = 1; rW2 = 7; busW2 = 16'hFFFF;
        tick();
        idle(); rS12 = 7; rS22 = 7; rS1 = 3;
        exp_q.push_back(64'hFFFF); exp_q.push_back(64'hFFFF); exp_q.push_back(64'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busA2 !== e[W2-1:0]) begin errors++; $display("FAIL small_r7_busA got %h exp %h", busA2, e[W2-1:0]); end
        e = exp_q.pop_front(); checks++;
        if (busB2 !== e[W2-1:0]) begin errors++; $display("FAIL small_r7_busB got %h exp %h", busB2, e[W2-1:0]); end
        e = exp_q.pop_front(); checks++;
        if (busyA0 !== e[0]) begin errors++; $display("FAIL pre_rst_busy3 got %b exp %b", busyA0, e[0]); end
        #2 reset = 1;
        model_clear();
        exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busA2 !== e[W2-1:0]) begin errors++; $display("FAIL async_rst_small_busA got %h exp %h", busA2, e[W2-1:0]); end
        e = exp_q.pop_front(); checks++;
        if (busA0 !== e[W-1:0]) begin errors++; $display("FAIL async_rst_busA got %h exp %h", busA0, e[W-1:0]); end
        e = exp_q.pop_front(); checks++;
        if (busyA0 !== e[0]) begin errors++; $display("FAIL async_rst_busyA got %b exp %b", busyA0, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (any0 !== e[0]) begin errors++; $display("FAIL async_rst_anyBusy got %b exp %b", any0, e[0]); end
        @(negedge clk);
        reset = 0;
        regWr = 1; rW = 3; busW = 32'h0000_0077;
        tick();
        idle(); rS1 = 3; rS12 = 7;
        exp_q.push_back(64'h77); exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busA0 !== e[W-1:0]) begin errors++; $display("FAIL post_rst_r3_data got %h exp %h", busA0, e[W-1:0]); end
        e = exp_q.pop_front(); checks++;
        if (busyA0 !== e[0]) begin errors++; $display("FAIL post_rst_r3_busy got %b exp %b", busyA0, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (any0 !== e[0]) begin errors++; $display("FAIL post_rst_anyBusy got %b exp %b", any0, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (busA2 !== e[W2-1:0]) begin errors++; $display("FAIL post_rst_small_r7 got %h exp %h", busA2, e[W2-1:0]); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [A-1:0] prev;
        prev = '0;
        for (int n = 0; n < 24; n++) begin
            regWr = 1; rW = A'($urandom_range(0, D-1)); busW = $urandom;
            setBusy = ($urandom_range(0, 2) == 0); rBusy = A'($urandom_range(0, D-1));
            rS1 = prev;
            rS2 = (n % 3 == 0) ? rW : A'($urandom_range(0, D-1));
            exp_q.push_back(64'(exp_read(rS1, 1'b1)));
            exp_q.push_back(64'(exp_read(rS2, 1'b1)));
            exp_q.push_back(64'(exp_read(rS2, 1'b0)));
            exp_q.push_back(64'(exp_busy(rS1, 1'b1)));
            exp_q.push_back(64'(exp_busy(rS2, 1'b0)));
            #1;
            e = exp_q.pop_front(); checks++;
            if (busA0 !== e[W-1:0]) begin errors++; $display("FAIL b2b[%0d] busA r%0d got %h exp %h", n, rS1, busA0, e[W-1:0]); end
            e = exp_q.pop_front(); checks++;
            if (busB0 !== e[W-1:0]) begin errors++; $display("FAIL b2b[%0d] busB r%0d got %h exp %h", n, rS2, busB0, e[W-1:0]); end
            e = exp_q.pop_front(); checks++;
            if (busB1 !== e[W-1:0]) begin errors++; $display("FAIL b2b[%0d] u1_busB r%0d got %h exp %h", n, rS2, busB1, e[W-1:0]); end
            e = exp_q.pop_front(); checks++;
            if (busyA0 !== e[0]) begin errors++; $display("FAIL b2b[%0d] busyA r%0d got %b exp %b", n, rS1, busyA0, e[0]); end
            e = exp_q.pop_front(); checks++;
            if (busyB1 !== e[0]) begin errors++; $display("FAIL b2b[%0d] u1_busyB r%0d got %b exp %b", n, rS2, busyB1, e[0]); end
            prev = rW;
            tick();
        end
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1;
        model_clear();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_bypass();
        test_busy();
        test_same_edge();
        test_small_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (legal range 8..64).
REQ-002 SHALL have parameter DEPTH, default 32, register count; must be a power of two, 4..64.
REQ-003 SHALL have parameter BYPASS, default 1; 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-004 SHALL derive AW = log2(DEPTH) internally; AW is not overridable.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port regWr, input, 1, write enable.
REQ-008 SHALL have port rW, input, AW, write address.
REQ-009 SHALL have port busW, input, WIDTH, write data.
REQ-010 SHALL have ports rS1 and rS2, input, AW each, read addresses for ports A and B.
REQ-011 SHALL have ports busA and busB, output, WIDTH each, read data.
REQ-012 SHALL have port setBusy, input, 1, marks a register as awaiting a pending write.
REQ-013 SHALL have port rBusy, input, AW, the register that setBusy marks.
REQ-014 SHALL have ports busyA and busyB, output, 1 each, scoreboard state of rS1 and rS2.
REQ-015 SHALL have port anyBusy, output, 1, OR of all scoreboard bits.

Function
REQ-016 SHALL read combinationally: busA = reg[rS1] and busB = reg[rS2], with no added latency.
REQ-017 SHALL write busW into reg[rW] on the rising clk edge when regWr=1 and rW!=0; the new value is visible on the read ports from the next cycle.
REQ-018 SHALL hardwire register 0 to zero: writes to it are discarded and reads of it return 0 under all conditions.
REQ-019 SHALL, when BYPASS=1, regWr=1, rW!=0 and rS1==rW, drive busA=busW in the same cycle; the same rule applies independently to rS2 and busB.
REQ-020 SHALL, when BYPASS=0, return only the stored value on a same-cycle read of the address being written.
REQ-021 SHALL keep one scoreboard bit per register: the bit sets on a clk edge with setBusy=1 and rBusy!=0, and clears on a clk edge with regWr=1 and rW equal to that register.
REQ-022 SHALL, when the set and clear of the same register fall on the same edge, leave the bit set (the new issue wins).
REQ-023 SHALL never set scoreboard bit 0.
REQ-024 SHALL drive busyA = busy[rS1] and busyB = busy[rS2] combinationally.
REQ-025 SHALL, when BYPASS=1, drive busyA=0 in a cycle where regWr=1 and rW==rS1!=0, because the pending data is being forwarded; the same rule applies to busyB.
REQ-026 SHALL leave setBusy on an already-busy register as busy, with no error and no counting.
REQ-027 SHALL give an address of DEPTH or greater no meaning; it cannot occur, since address width equals AW.

Reset
REQ-028 SHALL, while reset=1, immediately (asynchronously) clear all registers and all scoreboard bits to 0, regardless of clk.
REQ-029 SHALL, while reset=1, drive busA=busB=0, busyA=busyB=0 and anyBusy=0, ignoring regWr, setBusy and forwarding.
REQ-030 SHALL ignore any write or busy-set pending on the edge where reset deasserts; normal operation resumes on the first rising edge after deassertion.
REQ-031 SHALL clear all state when reset is asserted mid-operation (for example between setBusy and the matching write), so the matching write then only stores data.

Verification
REQ-032 SHALL be verified with this scenario: reset pulse, then read all addresses -> every busA/busB = 0, anyBusy = 0.
REQ-033 SHALL be verified with this scenario: write 0xDEADBEEF to r5, then read rS1=5 next cycle -> busA = 0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
REQ-034 SHALL be verified with this scenario: BYPASS=1, regWr=1, rW=7, busW=0xA5A5A5A5, rS1=rS2=7 in the same cycle -> busA = busB = 0xA5A5A5A5; repeat with BYPASS=0 -> old r7 value.
REQ-035 SHALL be verified with this scenario: setBusy with rBusy=9 -> busyA=1 for rS1=9 and anyBusy=1; then write r9 -> busyA=0 in that cycle (BYPASS=1) and bit clear afterwards.
REQ-036 SHALL be verified with this scenario: setBusy rBusy=3 and regWr rW=3 on the same edge -> r3 updated, busy[3] remains 1.
REQ-037 SHALL be verified with this scenario: WIDTH=16, DEPTH=8, write 0xFFFF to r7 -> reads 0xFFFF; then assert reset asynchronously mid-cycle -> busA goes to 0 before the next clk edge.
